// File: rtl/key_debounce.sv
// Key conditioning: two-flop synchroniser, four-state debounce filter,
// registered clean level, one-cycle press/release strobes and a wrapping press counter.
module key_debounce #(
    parameter int CNT_W   = 20,
    parameter int CNT_MAX = 999_999
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_n,
    output logic       key_level,
    output logic       key_press,
    output logic       key_release,
    output logic [7:0] press_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PFILT = 2'd1,
        DOWN  = 2'd2,
        RFILT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic             sync1_q, sync1_d;
    logic             key_s_q, key_s_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             key_level_q, key_level_d;
    logic             key_press_q, key_press_d;
    logic             key_release_q, key_release_d;
    logic [7:0]       press_cnt_q, press_cnt_d;

    always_comb begin
        sync1_d       = key_n;
        key_s_d       = sync1_q;
        state_d       = state_q;
        cnt_d         = cnt_q;
        key_press_d   = 1'b0;
        key_release_d = 1'b0;
        press_cnt_d   = press_cnt_q;
        case (state_q)
            IDLE: begin
                if (!key_s_q) begin
                    state_d = PFILT;
                    cnt_d   = '0;
                end
            end
            PFILT: begin
                // A single released sample throws away the whole press window.
                if (key_s_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_TOP) begin
                    state_d     = DOWN;
                    key_press_d = 1'b1;
                    press_cnt_d = press_cnt_q + 8'd1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DOWN: begin
                if (key_s_q) begin
                    state_d = RFILT;
                    cnt_d   = '0;
                end
            end
            RFILT: begin
                if (!key_s_q) begin
                    state_d = DOWN;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_TOP) begin
                    state_d       = IDLE;
                    key_release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        // Level follows the next state so it moves on the same edge as the strobes.
        key_level_d = (state_d == DOWN) || (state_d == RFILT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q       <= 1'b1;
            key_s_q       <= 1'b1;
            state_q       <= IDLE;
            cnt_q         <= '0;
            key_level_q   <= 1'b0;
            key_press_q   <= 1'b0;
            key_release_q <= 1'b0;
            press_cnt_q   <= 8'd0;
        end else begin
            sync1_q       <= sync1_d;
            key_s_q       <= key_s_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            key_level_q   <= key_level_d;
            key_press_q   <= key_press_d;
            key_release_q <= key_release_d;
            press_cnt_q   <= press_cnt_d;
        end
    end

    assign key_level   = key_level_q;
    assign key_press   = key_press_q;
    assign key_release = key_release_q;
    assign press_cnt   = press_cnt_q;

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: directed and random key waveforms checked each cycle
// against a run-length model of the debounced key.
module tb_key_debounce;

    localparam int CNT_MAX = 4;
    localparam int WIN     = CNT_MAX + 2;
    localparam int LAT     = CNT_MAX + 3;

    logic       clk;
    logic       rst;
    logic       key_n;
    logic       key_level;
    logic       key_press;
    logic       key_release;
    logic [7:0] press_cnt;

    key_debounce #(.CNT_W(20), .CNT_MAX(CNT_MAX)) dut (
        .clk         (clk),
        .rst         (rst),
        .key_n       (key_n),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .press_cnt   (press_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_press = 0;
    int n_release = 0;
    int press_cyc = -1;
    int release_cyc = -1;

    // Model: key samples reach the filter two edges late; the level flips once
    // WIN consecutive filter samples disagree with it.
    bit         dly_q[$];
    int         run;
    logic       m_level;
    logic       m_press;
    logic       m_release;
    logic [7:0] m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        dly_q     = '{1'b1, 1'b1};
        run       = 0;
        m_level   = 1'b0;
        m_press   = 1'b0;
        m_release = 1'b0;
        m_cnt     = 8'd0;
    endtask

    task automatic model_edge(input logic kn);
        bit s;
        s = dly_q.pop_front();
        dly_q.push_back(kn);
        m_press   = 1'b0;
        m_release = 1'b0;
        if ((!s) != m_level) run++;
        else run = 0;
        if (run == WIN) begin
            run     = 0;
            m_level = !m_level;
            if (m_level) begin
                m_press = 1'b1;
                m_cnt   = m_cnt + 8'd1;
            end else begin
                m_release = 1'b1;
            end
        end
    endtask

    task automatic check_outputs();
        chk("key_level", 32'(key_level), 32'(m_level));
        chk("key_press", 32'(key_press), 32'(m_press));
        chk("key_release", 32'(key_release), 32'(m_release));
        chk("press_cnt", 32'(press_cnt), 32'(m_cnt));
    endtask

    task automatic step(input logic kn);
        key_n = kn;
        @(posedge clk);
        cyc++;
        model_edge(kn);
        #1;
        check_outputs();
        if (key_press === 1'b1) begin
            n_press++;
            press_cyc = cyc;
        end
        if (key_release === 1'b1) begin
            n_release++;
            release_cyc = cyc;
        end
    endtask

    task automatic drive(input logic kn, input int n);
        for (int i = 0; i < n; i++) step(kn);
    endtask

    // Asserted between edges; outputs must clear without waiting for a clock.
    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        #2;
        rst = 1'b1;
    endtask

    initial begin
        #100_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e0;
        int p0;
        int r0;
        rst   = 1'b1;
        key_n = 1'b1;
        #2;
        do_reset();

        // Clean press then release.
        e0 = cyc + 1;
        drive(1'b0, 20);
        chk("clean_press_time", 32'(press_cyc), 32'(e0 + LAT));
        chk("clean_level_high", 32'(key_level), 32'd1);
        e0 = cyc + 1;
        drive(1'b1, 20);
        chk("clean_release_time", 32'(release_cyc), 32'(e0 + LAT));
        chk("clean_press_cnt", 32'(press_cnt), 32'd1);

        // Press bounce: only the final stable low produces a strobe.
        p0 = n_press;
        drive(1'b0, 3);
        drive(1'b1, 1);
        drive(1'b0, 2);
        drive(1'b1, 1);
        e0 = cyc + 1;
        drive(1'b0, 12);
        chk("bounce_press_count", 32'(n_press - p0), 32'd1);
        chk("bounce_press_time", 32'(press_cyc), 32'(e0 + LAT));
        drive(1'b1, 12);

        // Release glitch shorter than the window.
        drive(1'b0, 10);
        r0 = n_release;
        drive(1'b1, 3);
        chk("glitch_level_mid", 32'(key_level), 32'd1);
        drive(1'b0, 10);
        chk("glitch_no_release", 32'(n_release - r0), 32'd0);
        chk("glitch_level_end", 32'(key_level), 32'd1);
        drive(1'b1, 12);

        // Reset while press filter has counted to 2.
        drive(1'b0, 5);
        do_reset();
        p0 = n_press;
        e0 = cyc + 1;
        drive(1'b0, 10);
        chk("rst_pfilt_press_time", 32'(press_cyc), 32'(e0 + LAT));
        chk("rst_pfilt_press_cnt", 32'(press_cnt), 32'd1);
        chk("rst_pfilt_press_count", 32'(n_press - p0), 32'd1);

        // Reset while held down: no release, fresh press afterwards.
        r0 = n_release;
        p0 = n_press;
        do_reset();
        drive(1'b0, 10);
        chk("rst_down_release", 32'(n_release - r0), 32'd0);
        chk("rst_down_press_count", 32'(n_press - p0), 32'd1);
        chk("rst_down_press_cnt", 32'(press_cnt), 32'd1);
        drive(1'b1, 12);

        // Random bursts of assorted lengths around the window size.
        for (int b = 0; b < 60; b++) begin
            drive(1'($urandom_range(0, 1)), $urandom_range(1, 9));
        end
        drive(1'b1, 12);

        // Counter wrap over 256 clean presses.
        do_reset();
        p0 = n_press;
        r0 = n_release;
        for (int i = 1; i <= 256; i++) begin
            drive(1'b0, 8);
            if (i == 255) chk("wrap_cnt_255", 32'(press_cnt), 32'd255);
            drive(1'b1, 8);
        end
        chk("wrap_press_count", 32'(n_press - p0), 32'd256);
        chk("wrap_release_count", 32'(n_release - r0), 32'd256);
        chk("wrap_cnt_end", 32'(press_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
